// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
//   Hardwired control unit for the DataPath. Steps through fetch (T0..T2) and
//   an opcode-dependent execute sequence (T3..T7), one step per clock, and
//   drives the bus-source, register-load, ALU and memory strobes combinationally
//   from the current step and the opcode in IR[31:27].
//
// Ports
//   clock    in   system clock, rising edge
//   clear    in   asynchronous reset, active-low (forces RST)
//   IR       in   instruction register contents, opcode = IR[31:27]
//   Stop     in   halt request, sampled only when leaving an instruction's last step
//   PCout, Zlowout, MDRout, BAout, Rout, Csignout     bus-source selects
//   PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin         register load enables
//   Gra, Grb, Grc                                      IR register-field selects
//   IncPC, ADD, SUB, AND, OR                           ALU operation selects
//   Read, Write, MD_read                               memory strobes / MDR source
//   Run      out  1 in T0..T7, 0 in RST and HALT
//   step     out  current step: 0..7 = T0..T7, 4'hE = RST, 4'hF = HALT
// ----------------------------------------------------------------------------
module control_sequencer #(
   parameter logic [4:0] OP_LD   = 5'b00000,
   parameter logic [4:0] OP_LDI  = 5'b00001,
   parameter logic [4:0] OP_ST   = 5'b00010,
   parameter logic [4:0] OP_ADD  = 5'b00011,
   parameter logic [4:0] OP_SUB  = 5'b00100,
   parameter logic [4:0] OP_AND  = 5'b00101,
   parameter logic [4:0] OP_OR   = 5'b00110,
   parameter logic [4:0] OP_ADDI = 5'b01100,
   parameter logic [4:0] OP_NOP  = 5'b11010,
   parameter logic [4:0] OP_HALT = 5'b11011
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        Stop,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        BAout,
   output logic        Rout,
   output logic        Csignout,
   output logic        PCin,
   output logic        MARin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlowin,
   output logic        Rin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        IncPC,
   output logic        ADD,
   output logic        SUB,
   output logic        AND,
   output logic        OR,
   output logic        Read,
   output logic        Write,
   output logic        MD_read,
   output logic        Run,
   output logic [3:0]  step
);

   // State code doubles as the externally visible step number.
   localparam logic [3:0] ST_T0   = 4'h0;
   localparam logic [3:0] ST_T1   = 4'h1;
   localparam logic [3:0] ST_T2   = 4'h2;
   localparam logic [3:0] ST_T3   = 4'h3;
   localparam logic [3:0] ST_T4   = 4'h4;
   localparam logic [3:0] ST_T5   = 4'h5;
   localparam logic [3:0] ST_T6   = 4'h6;
   localparam logic [3:0] ST_T7   = 4'h7;
   localparam logic [3:0] ST_RST  = 4'hE;
   localparam logic [3:0] ST_HALT = 4'hF;

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic [4:0] opcode;
   logic       unused_ir;

   logic is_alu;    // add/sub/and/or
   logic is_ldi;
   logic is_addi;
   logic is_ld;
   logic is_st;
   logic is_halt;
   logic is_addr;   // ldi/addi/ld/st: share the base+C computation in T3/T4
   logic is_exec;   // has any execute steps at all

   assign opcode    = IR[31:27];
   assign unused_ir = ^IR[26:0];

   always_comb begin
      is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                (opcode == OP_AND) || (opcode == OP_OR);
      is_ldi  = (opcode == OP_LDI);
      is_addi = (opcode == OP_ADDI);
      is_ld   = (opcode == OP_LD);
      is_st   = (opcode == OP_ST);
      is_halt = (opcode == OP_HALT);
      is_addr = is_ldi || is_addi || is_ld || is_st;
      is_exec = is_alu || is_addr;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear)
         state <= ST_RST;
      else
         state <= state_nxt;
   end

   // Stop is only looked at on the transition out of an instruction's final
   // step (T2 for nop/undefined, T5 for 6-cycle ops, T7 for ld/st).
   always_comb begin
      state_nxt = ST_RST;
      case (state)
         ST_RST:  state_nxt = ST_T0;
         ST_T0:   state_nxt = ST_T1;
         ST_T1:   state_nxt = ST_T2;
         ST_T2: begin
            if (is_halt)
               state_nxt = ST_HALT;
            else if (is_exec)
               state_nxt = ST_T3;
            else
               state_nxt = Stop ? ST_HALT : ST_T0;
         end
         ST_T3:   state_nxt = ST_T4;
         ST_T4:   state_nxt = ST_T5;
         ST_T5: begin
            if (is_ld || is_st)
               state_nxt = ST_T6;
            else
               state_nxt = Stop ? ST_HALT : ST_T0;
         end
         ST_T6:   state_nxt = ST_T7;
         ST_T7:   state_nxt = Stop ? ST_HALT : ST_T0;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_RST;
      endcase
   end

   always_comb begin
      PCout    = 1'b0;
      Zlowout  = 1'b0;
      MDRout   = 1'b0;
      BAout    = 1'b0;
      Rout     = 1'b0;
      Csignout = 1'b0;
      PCin     = 1'b0;
      MARin    = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zlowin   = 1'b0;
      Rin      = 1'b0;
      Gra      = 1'b0;
      Grb      = 1'b0;
      Grc      = 1'b0;
      IncPC    = 1'b0;
      ADD      = 1'b0;
      SUB      = 1'b0;
      AND      = 1'b0;
      OR       = 1'b0;
      Read     = 1'b0;
      Write    = 1'b0;
      MD_read  = 1'b0;
      case (state)
         ST_T0: begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            Zlowin = 1'b1;
         end
         ST_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MD_read = 1'b1;
            MDRin   = 1'b1;
         end
         ST_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         ST_T3: begin
            if (is_alu) begin
               Grb  = 1'b1;
               Rout = 1'b1;
               Yin  = 1'b1;
            end else if (is_addr) begin
               Grb   = 1'b1;
               Yin   = 1'b1;
               // addi reads the register itself; the other address forms use
               // BAout so that R0 reads as zero.
               Rout  = is_addi;
               BAout = !is_addi;
            end
         end
         ST_T4: begin
            if (is_alu) begin
               Grc    = 1'b1;
               Rout   = 1'b1;
               Zlowin = 1'b1;
               ADD    = (opcode == OP_ADD);
               SUB    = (opcode == OP_SUB);
               AND    = (opcode == OP_AND);
               OR     = (opcode == OP_OR);
            end else if (is_addr) begin
               Csignout = 1'b1;
               ADD      = 1'b1;
               Zlowin   = 1'b1;
            end
         end
         ST_T5: begin
            if (is_alu || is_ldi || is_addi) begin
               Zlowout = 1'b1;
               Gra     = 1'b1;
               Rin     = 1'b1;
            end else if (is_ld || is_st) begin
               Zlowout = 1'b1;
               MARin   = 1'b1;
            end
         end
         ST_T6: begin
            if (is_ld) begin
               Read    = 1'b1;
               MD_read = 1'b1;
               MDRin   = 1'b1;
            end else if (is_st) begin
               Gra   = 1'b1;
               Rout  = 1'b1;
               MDRin = 1'b1;
            end
         end
         ST_T7: begin
            if (is_ld) begin
               MDRout = 1'b1;
               Gra    = 1'b1;
               Rin    = 1'b1;
            end else if (is_st) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign Run  = (state <= ST_T7);
   assign step = state;

endmodule
